// File: rtl/snake_tile_renderer.sv
// Snake tile-map renderer: Avalon-written 32x64 map of 4-bit codes -> sprite texels -> RGB.
// 3 clk from hcount/vcount/sync inputs to VGA outputs; no backpressure (Avalon accepts every cycle).
module snake_tile_renderer #(
  parameter int          TILE_LOG2   = 4,
  parameter int          MAP_COLS    = 40,
  parameter int          MAP_ROWS    = 30,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n
);

  localparam int TW = TILE_LOG2;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t  state;
  logic        start_pend;
  logic [10:0] clr_addr;
  logic        busy;

  logic [5:0]  tile_x;
  logic [4:0]  tile_y;
  logic [7:0]  bg_r, bg_g, bg_b;

  logic [3:0]  tile_mem [0:2047];
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [3:0]  ram_wdata;

  logic        av_wr;
  logic        commit;

  assign busy   = (state == CLEAR);
  assign av_wr  = chipselect && write;
  // The pending post-reset sweep also blocks commits for its start cycle.
  assign commit = av_wr && (address == 3'd2) && !busy && !start_pend;

  // Sprite art: procedural lookup indexed {code, py, px}; the top-left texel of
  // every sprite is the transparent key so sprite edges can show the background.
  function automatic logic [23:0] sprite_texel(input logic [3:0] code,
                                               input logic [TW-1:0] py,
                                               input logic [TW-1:0] px);
    logic [7:0] r, g, b;
    r = {code, 4'h0};
    g = 8'({py, 4'h0});
    b = 8'({px, 4'h0});
    if (py == '0 && px == '0)
      return TRANSPARENT;
    return {r, g, b};
  endfunction

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {tile_y, tile_x};
    ram_wdata = writedata[3:0];
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = 4'h0;
    end else if (commit && !writedata[7]) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      tile_mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_pend <= 1'b1;
      clr_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pend || (commit && writedata[7])) begin
            state      <= CLEAR;
            start_pend <= 1'b0;
            clr_addr   <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 11'd1;
          if (clr_addr == 11'd2047)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_x   <= '0;
      tile_y   <= '0;
      bg_r     <= 8'h00;
      bg_g     <= 8'h00;
      bg_b     <= 8'h80;
      readdata <= 8'h00;
    end else begin
      if (av_wr) begin
        case (address)
          3'd0: tile_x <= writedata[5:0];
          3'd1: tile_y <= writedata[4:0];
          3'd4: bg_r   <= writedata;
          3'd5: bg_g   <= writedata;
          3'd6: bg_b   <= writedata;
          default: ;
        endcase
      end
      if (chipselect && read) begin
        case (address)
          3'd0:    readdata <= {2'b00, tile_x};
          3'd1:    readdata <= {3'b000, tile_y};
          3'd3:    readdata <= {7'b0, busy};
          3'd4:    readdata <= bg_r;
          3'd5:    readdata <= bg_g;
          3'd6:    readdata <= bg_b;
          default: readdata <= 8'h00;
        endcase
      end
    end
  end

  // Display pipeline
  logic [10:0]   row_full, col_full;
  logic [10:0]   raddr;
  logic          outside0;

  assign row_full = 11'(vcount >> TW);
  assign col_full = 11'(hcount >> (TW + 1));
  assign raddr    = {row_full[4:0], col_full[5:0]};
  assign outside0 = (col_full >= 11'(MAP_COLS)) || (row_full >= 11'(MAP_ROWS));

  logic [3:0]    code1, code2;
  logic [TW-1:0] py1, px1;
  logic          out1, out2;
  logic          hs1, vs1, bl1, hs2, vs2, bl2;
  logic [23:0]   texel2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code1 <= '0; py1 <= '0; px1 <= '0; out1 <= 1'b0;
      hs1 <= 1'b1; vs1 <= 1'b1; bl1 <= 1'b0;
      code2 <= '0; texel2 <= '0; out2 <= 1'b0;
      hs2 <= 1'b1; vs2 <= 1'b1; bl2 <= 1'b0;
      VGA_R <= 8'h00; VGA_G <= 8'h00; VGA_B <= 8'h00;
      VGA_HS <= 1'b1; VGA_VS <= 1'b1; VGA_BLANK_n <= 1'b0;
    end else begin
      code1 <= tile_mem[raddr];
      py1   <= vcount[TW-1:0];
      px1   <= hcount[TW:1];
      out1  <= outside0;
      hs1   <= hs_in;
      vs1   <= vs_in;
      bl1   <= blank_n_in;

      texel2 <= sprite_texel(code1, py1, px1);
      code2  <= code1;
      out2   <= out1;
      hs2    <= hs1;
      vs2    <= vs1;
      bl2    <= bl1;

      if (!bl2)
        {VGA_R, VGA_G, VGA_B} <= 24'h000000;
      else if (code2 == 4'h0 || texel2 == TRANSPARENT || out2)
        {VGA_R, VGA_G, VGA_B} <= {bg_r, bg_g, bg_b};
      else
        {VGA_R, VGA_G, VGA_B} <= texel2;
      VGA_HS      <= hs2;
      VGA_VS      <= vs2;
      VGA_BLANK_n <= bl2;
    end
  end

endmodule
